store_buffer: RTL

- Posted-write buffer between the byte-enable store formatter and the data-memory/bridge port.
- Accepts formatted stores (address, lane-aligned write data, byte enables) from the MEM stage in one cycle.
- Drains them in order to memory over a req/ack handshake, so slow devices do not stall the pipeline on stores.
- Flags loads that alias a pending store, so the pipeline stalls them until the store drains.

---
 rtl/store_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drained over a mem_req/mem_ack handshake.
// Define STORE_BUF_MERGE_EN to merge same-word stores into the tail entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_wdata,
    input  logic [3:0]    in_byteen,
    output logic          in_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hazard,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_byteen,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [AW-1:0] WMASK = {{(AW-2){1'b1}}, 2'b00};

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state;
    logic [AW-1:0]     addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     tail_last;
    logic [PW:0]       count;
    logic [PW:0]       count_nxt;
    logic              not_full;
    logic              merge_ok;
    logic              accept;
    logic              real_store;
    logic              do_merge;
    logic              do_push;
    logic              do_pop;
    logic              hit;

    assign tail_last = tail - PW'(1);
    assign not_full  = count < FULL;

    // The tail may only absorb a store while it is not the entry on the bus.
    assign merge_ok = (count != '0)
                   && (((addr_q[tail_last] ^ in_addr) & WMASK) == '0)
                   && !(state == REQ && tail_last == head);

`ifdef STORE_BUF_MERGE_EN
    assign in_ready = not_full || merge_ok;
    assign do_merge = real_store && merge_ok;
`else
    assign in_ready = not_full;
    assign do_merge = 1'b0;
`endif

    assign accept     = in_valid && in_ready;
    assign real_store = accept && (in_byteen != 4'b0000);
    assign do_push    = real_store && !do_merge;
    assign do_pop     = (state == REQ) && mem_ack;

    assign count_nxt = count
                     + {{PW{1'b0}}, do_push}
                     - {{PW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld_q <= '0;
        end else begin
            count <= count_nxt;
            state <= (count_nxt != '0) ? REQ : IDLE;
            if (do_pop) begin
                vld_q[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (do_push) begin
                vld_q[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_wdata;
            be_q[tail]   <= in_byteen;
        end else if (do_merge) begin
            be_q[tail_last] <= be_q[tail_last] | in_byteen;
            for (int b = 0; b < 4; b++) begin
                if (in_byteen[b]) begin
                    data_q[tail_last][8*b +: 8] <= in_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (((addr_q[i] ^ ld_addr) & WMASK) == '0)) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_hazard  = ld_valid && hit;
    assign mem_req    = (state == REQ);
    assign mem_addr   = mem_req ? addr_q[head] : '0;
    assign mem_wdata  = mem_req ? data_q[head] : '0;
    assign mem_byteen = mem_req ? be_q[head]   : '0;
    assign empty      = (count == '0) && (state == IDLE);

endmodule
